seq_normalizer: RTL
===================

SEQ_NORMALIZER -- requirements
Module: seq_normalizer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the data word width; only powers of two from 4 to 32 are legal.
REQ-002 The block SHALL derive CNT_W = log2(DATA_W) internally; it SHALL NOT be a user parameter.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to normalize din.
REQ-007 The block SHALL have port din, input, DATA_W bits: word to normalize.
REQ-008 The block SHALL have port dir, input, 1 bit: 0 = normalize toward MSB (shift left); 1 = normalize toward LSB (shift right).
REQ-009 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port dout, output, DATA_W bits: normalized word.
REQ-012 The block SHALL have port cnt, output, CNT_W bits: number of single-bit shifts applied.
REQ-013 The block SHALL have port zero, output, 1 bit: the captured word was all zeros.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL capture din and dir into the work register, clear the count, and enter SHIFT.
REQ-016 In SHIFT, start SHALL be ignored.
REQ-017 In SHIFT, on each edge the FSM SHALL enter DONE if any of these hold: the target bit is 1 (bit DATA_W-1 for dir=0, bit 0 for dir=1), the work register is zero, or the count equals DATA_W-1.
REQ-018 Otherwise, on that edge the work register SHALL shift one position toward the target bit, zero-fill the vacated end, and increment the count by 1.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unless start=1 (REQ-015).
REQ-020 Latency: with N = shifts required, done SHALL be high during the cycle following edge N+1 after the capturing edge; N is between 0 and DATA_W-1.
REQ-021 busy SHALL be 1 exactly while in SHIFT.
REQ-022 done SHALL be 1 exactly while in DONE.
REQ-023 dout, cnt and zero SHALL update on the edge entering DONE and hold until the next completion.
REQ-024 For an all-zero captured word, the result SHALL be dout=0, cnt=0, zero=1, with done after edge 1.
REQ-025 The count SHALL never wrap.
REQ-026 The original word SHALL be recoverable: shifting dout by cnt in the direction opposite to dir reproduces the captured word.

Reset
REQ-027 On rst_n=0, asynchronously and including mid-operation, the FSM SHALL go to IDLE with busy=0, done=0, dout=0, cnt=0, zero=0.
REQ-028 Any in-flight operation SHALL be discarded on reset, with no done pulse.
REQ-029 After rst_n deasserts, the first start SHALL behave per REQ-015.

Configuration
REQ-030 With macro NORM_ABORT_EN defined, the block SHALL add input port abort (1 bit); abort=1 in SHIFT SHALL return the FSM to IDLE on the next edge with no done pulse and dout/cnt/zero unchanged; abort SHALL take priority over completion on the same edge.
REQ-031 Without NORM_ABORT_EN, the abort port SHALL NOT exist and the behaviour SHALL be exactly REQ-014 to REQ-029.

Verification
REQ-032 The bench SHALL check: din=0x80, dir=0, start -> done after edge 1, dout=0x80, cnt=0, zero=0.
REQ-033 The bench SHALL check: din=0x01, dir=0 -> busy for 8 cycles, done after edge 8, dout=0x80, cnt=7.
REQ-034 The bench SHALL check: din=0x16, dir=0 -> dout=0xB0, cnt=3; then din=0x16, dir=1 -> dout=0x0B, cnt=1.
REQ-035 The bench SHALL check: din=0x00 -> done after edge 1, dout=0x00, cnt=0, zero=1; also start pulsed during SHIFT with a different din -> ignored, first result delivered unchanged.
REQ-036 The bench SHALL check: rst_n=0 mid-SHIFT on din=0x01 -> immediate busy=0, dout=0, cnt=0, no done; a following start on din=0x04, dir=0 -> dout=0x80, cnt=5.
REQ-037 With NORM_ABORT_EN, the bench SHALL check: abort at edge 3 of din=0x01, dir=0 -> IDLE, no done, previous dout/cnt held.

Source files
------------

// File: rtl/seq_normalizer.sv
// Normalizer: shifts a word one bit per cycle until its target end bit is set.
// Optional NORM_ABORT_EN adds an abort input that cancels an operation in SHIFT.
module seq_normalizer #(
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [DATA_W-1:0]          din,
    input  logic                       dir,
`ifdef NORM_ABORT_EN
    input  logic                       abort,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DATA_W)-1:0]  cnt,
    output logic                       zero
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [DATA_W-1:0]  r_work;
    logic               r_dir;
    logic [CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_dout;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_zero;
    logic               w_capture;
    logic               w_target;
    logic               w_work_zero;
    logic               w_finish;
    logic               w_abort;

`ifdef NORM_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_capture   = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_target    = r_dir ? r_work[0] : r_work[DATA_W-1];
    assign w_work_zero = (r_work == '0);
    // Count limit is a safety net; a nonzero word reaches its target first.
    assign w_finish    = w_target || w_work_zero || (r_count == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  w_next_state = start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: begin
                if (w_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_finish) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = start ? ST_SHIFT : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_SHIFT);
        done = (r_state == ST_DONE);
    end

    // Results are registered only on the edge entering DONE, so an abort leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_dir   <= 1'b0;
            r_count <= '0;
            r_dout  <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
        end else if (w_capture) begin
            r_work  <= din;
            r_dir   <= dir;
            r_count <= '0;
        end else if (r_state == ST_SHIFT && !w_abort) begin
            if (w_finish) begin
                r_dout <= r_work;
                r_cnt  <= r_count;
                r_zero <= w_work_zero;
            end else begin
                r_work  <= r_dir ? {1'b0, r_work[DATA_W-1:1]} : {r_work[DATA_W-2:0], 1'b0};
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign dout = r_dout;
    assign cnt  = r_cnt;
    assign zero = r_zero;

endmodule
